i2c_slave_regs: RTL
===================

// Module: i2c_slave_regs
// PURPOSE
//  I2C target (slave) that responds to an I2C master on the same SCL/SDA bus. Exposes a byte-wide
//  register bus to local logic. Supports pointer write, data write with auto-increment, and
//  random/sequential read through a repeated START. It is the responder counterpart of the I2C
//  master and is used for board-level loopback and for sensor emulation.
// PARAMETERS
//  SLAVE_ADDR   7'h42  7-bit bus address this target ACKs
//  FILT_LEN     3      consecutive equal samples required before a filtered SCL/SDA level changes
//  HOLD_CYC     15     clk cycles after SCL fall before SDA is driven/released (tHD;DAT = 300 ns)
// PORTS
//  clk_50mhz   in     1  50 MHz system clock
//  rst         in     1  synchronous, active-high reset
//  scl         in     1  I2C clock line (target never stretches)
//  sda         inout  1  I2C data line; open-drain: driven 1'b0 or 1'bz, never 1'b1
//  reg_addr    out    8  register pointer
//  reg_wdata   out    8  write data; valid while reg_we=1
//  reg_we      out    1  1-cycle write strobe
//  reg_re      out    1  1-cycle read strobe; reg_rdata is sampled on the next clk
//  reg_rdata   in     8  read data from local register file
//  busy        out    1  high from an address-matched START until STOP
//  ack         out    1  1-cycle pulse on each ACK this target drives
// BEHAVIOUR
//  Reset: sda=z, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, ack=0, state=IDLE.
//  Input path: each line passes through a 2-FF sync, then a FILT_LEN filter. All edges are taken
//   on filtered levels. Edge detect is a 1-cycle pulse: scl_rise, scl_fall, sda_rise, sda_fall.
//  START = sda_fall while SCL=1. STOP = sda_rise while SCL=1. Both are legal in any state.
//   START: go to ADDR; clear bit counter; keep reg_addr. STOP: go to IDLE; release sda; busy=0.
//  Data is sampled on scl_rise, MSB first. SDA changes only HOLD_CYC cycles after scl_fall.
//  States:
//   IDLE      wait for START
//   ADDR      shift 8 bits. [7:1]==SLAVE_ADDR -> ADDR_ACK and busy=1. Otherwise -> IGNORE
//             (sda z until STOP/START).
//   ADDR_ACK  drive 0 for the 9th clock; pulse ack. R/W=0 -> PTR. R/W=1 -> assert reg_re,
//             latch reg_rdata into tx shift reg, then RD_DATA.
//   PTR       shift 8 bits -> reg_addr at 8th scl_rise; go to PTR_ACK.
//   PTR_ACK   drive 0 for the 9th clock -> WR_DATA.
//   WR_DATA   shift 8 bits; at 8th scl_rise set reg_wdata and pulse reg_we for 1 cycle.
//   WR_ACK    drive 0 for the 9th clock; reg_addr += 1 (8-bit wrap FF->00) -> WR_DATA.
//   RD_DATA   drive tx bit (0 -> pull low, 1 -> z) per bit; after 8th bit release sda -> RD_ACK.
//   RD_ACK    sample master bit at scl_rise. 0 (ACK): reg_addr += 1, assert reg_re, reload tx,
//             then RD_DATA. 1 (NACK): -> IGNORE.
//  reg_re fires at least HOLD_CYC cycles before the first bit is driven, so the tx reg is loaded first.
//  Simultaneous: START/STOP take priority over a same-cycle scl edge. reg_we and reg_re never
//   assert together.
//  Repeated START after PTR gives a random read from the written pointer. The pointer persists
//   across transactions.
//  rst asserted mid-transfer: sda released in the same cycle; all state returns to reset values.
//  The target never drives SDA outside ACK slots and RD_DATA. It never drives SDA while SCL is high
//   except to hold a bit that was already stable.
// STRUCTURE
//  Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA,
//   RD_ACK, IGNORE), I2C_RW_READ=1'b1, I2C_ACK=1'b0 constants. The master shares this package.
//  Sub-module i2c_line_filter (param FILT_LEN): sync + glitch filter + rise/fall pulses. Instanced
//   twice, once for scl and once for sda.
//  Top holds the FSM, bit counter (0..8), rx/tx shift registers, and the hold-delay counter.
// TESTING
//  BFM master at 100 kHz, pull-up model on sda (weak 1 when z).
//  1 Write: S 0x84 A 0x10 A 0xAB A 0xCD A P -> reg_we pulses: (0x10,0xAB), (0x11,0xCD). 4 acks.
//  2 Random read: S 0x84 0x20 Sr 0x85, regs[0x20]=0x5A, [0x21]=0xC3, master ACK then NACK, P ->
//    bytes 0x5A, 0xC3 on sda; reg_re x2; reg_addr=0x21 at end.
//  3 Wrong address 0x86 -> no ACK (sda stays 1 on the 9th clock), no strobes, busy stays 0.
//  4 Pointer wrap: write pointer 0xFF, 2 data bytes -> writes to 0xFF then 0x00.
//  5 Glitch of 2 clk on scl during ADDR -> ignored, address still matches. rst mid-RD_DATA -> sda z
//    next cycle, state IDLE.
//  6 STOP in the middle of a byte in WR_DATA -> no reg_we, busy=0, next START accepted normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C
// master and target.
`timescale 1ns/1ps
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchroniser, FILT_LEN-sample glitch filter
// and single-cycle rise/fall pulses for one I2C line.
`timescale 1ns/1ps
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    r_sync;
    logic          r_lvl;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Level flips only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_lvl  <= 1'b1;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_LEN - 1)) begin
                r_lvl  <= r_sync[1];
                r_cnt  <= '0;
                r_rise <= r_sync[1];
                r_fall <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_lvl;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target bridging bus transfers onto a byte-wide
// register port with pointer write, auto-increment and random read.
`timescale 1ns/1ps
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int         FILT_LEN   = 3,
    parameter int         HOLD_CYC   = 15
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       ack
);
    localparam int HW = $clog2(HOLD_CYC + 1);

    i2c_state_e r_state, w_state_nx;
    logic [3:0]    r_bitcnt, w_bitcnt_nx;
    logic [7:0]    r_rx, w_rx_nx;
    logic [7:0]    r_tx, w_tx_nx;
    logic [7:0]    r_addr, w_addr_nx;
    logic [7:0]    r_wdata, w_wdata_nx;
    logic          r_rw, w_rw_nx;
    logic          r_we, w_we_nx;
    logic          r_re, w_re_nx;
    logic          r_ack, w_ack_nx;
    logic          r_busy, w_busy_nx;
    logic          r_sda_low, r_pend;
    logic [HW-1:0] r_hold;
    logic          w_sched, w_kill, w_drv;

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_last;
    logic [7:0] w_byte;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk_50mhz),
        .rst     (rst),
        .i_line  (scl),
        .o_level (w_scl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk_50mhz),
        .rst     (rst),
        .i_line  (sda),
        .o_level (w_sda),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_rx[6:0], w_sda};
    assign w_last  = (r_bitcnt == 4'd7);

    always_ff @(posedge clk_50mhz) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_bitcnt_nx = r_bitcnt;
        w_rx_nx     = r_rx;
        w_tx_nx     = r_re ? reg_rdata : r_tx;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;
        w_rw_nx     = r_rw;
        w_we_nx     = 1'b0;
        w_re_nx     = 1'b0;
        w_ack_nx    = 1'b0;
        w_busy_nx   = r_busy;
        w_sched     = 1'b0;
        w_kill      = 1'b0;
        w_drv       = 1'b0;
        if (w_start) begin
            w_state_nx  = ADDR;
            w_bitcnt_nx = 4'd0;
            w_kill      = 1'b1;
        end else if (w_stop) begin
            w_state_nx  = IDLE;
            w_bitcnt_nx = 4'd0;
            w_busy_nx   = 1'b0;
            w_kill      = 1'b1;
        end else if (w_scl_rise) begin
            case (r_state)
                ADDR: begin
                    w_rx_nx     = w_byte;
                    w_bitcnt_nx = r_bitcnt + 4'd1;
                    if (w_last && w_byte[7:1] == SLAVE_ADDR) begin
                        w_state_nx = ADDR_ACK;
                        w_busy_nx  = 1'b1;
                        w_ack_nx   = 1'b1;
                        w_rw_nx    = w_byte[0];
                        w_re_nx    = (w_byte[0] == I2C_RW_READ);
                    end else if (w_last) begin
                        w_state_nx = IGNORE;
                    end
                end
                PTR: begin
                    w_rx_nx     = w_byte;
                    w_bitcnt_nx = r_bitcnt + 4'd1;
                    if (w_last) begin
                        w_addr_nx  = w_byte;
                        w_state_nx = PTR_ACK;
                        w_ack_nx   = 1'b1;
                    end
                end
                WR_DATA: begin
                    w_rx_nx     = w_byte;
                    w_bitcnt_nx = r_bitcnt + 4'd1;
                    if (w_last) begin
                        w_wdata_nx = w_byte;
                        w_we_nx    = 1'b1;
                        w_state_nx = WR_ACK;
                        w_ack_nx   = 1'b1;
                    end
                end
                // Zero count marks the 9th clock as seen.
                ADDR_ACK, PTR_ACK, WR_ACK: w_bitcnt_nx = 4'd0;
                RD_DATA: begin
                    w_tx_nx     = {r_tx[6:0], 1'b1};
                    w_bitcnt_nx = r_bitcnt + 4'd1;
                    if (w_last) w_state_nx = RD_ACK;
                end
                RD_ACK: begin
                    if (w_sda == I2C_ACK) begin
                        w_addr_nx   = r_addr + 8'd1;
                        w_re_nx     = 1'b1;
                        w_state_nx  = RD_DATA;
                        w_bitcnt_nx = 4'd0;
                    end else begin
                        w_state_nx = IGNORE;
                    end
                end
                default: ;
            endcase
        end else if (w_scl_fall) begin
            w_sched = 1'b1;
            case (r_state)
                ADDR_ACK: begin
                    if (r_bitcnt == 4'd8) begin
                        w_drv = 1'b1;
                    end else if (r_rw == I2C_RW_READ) begin
                        w_state_nx  = RD_DATA;
                        w_bitcnt_nx = 4'd0;
                        w_drv       = ~r_tx[7];
                    end else begin
                        w_state_nx  = PTR;
                        w_bitcnt_nx = 4'd0;
                    end
                end
                PTR_ACK: begin
                    if (r_bitcnt == 4'd8) begin
                        w_drv = 1'b1;
                    end else begin
                        w_state_nx  = WR_DATA;
                        w_bitcnt_nx = 4'd0;
                    end
                end
                WR_ACK: begin
                    if (r_bitcnt == 4'd8) begin
                        w_drv = 1'b1;
                    end else begin
                        w_addr_nx   = r_addr + 8'd1;
                        w_state_nx  = WR_DATA;
                        w_bitcnt_nx = 4'd0;
                    end
                end
                RD_DATA: w_drv = ~r_tx[7];
                default: w_drv = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_bitcnt  <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw      <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_sda_low <= 1'b0;
            r_pend    <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_bitcnt <= w_bitcnt_nx;
            r_rx     <= w_rx_nx;
            r_tx     <= w_tx_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_rw     <= w_rw_nx;
            r_we     <= w_we_nx;
            r_re     <= w_re_nx;
            r_ack    <= w_ack_nx;
            r_busy   <= w_busy_nx;
            // SDA only changes once the hold time after SCL fall has elapsed.
            if (w_kill) begin
                r_sda_low <= 1'b0;
                r_hold    <= '0;
            end else if (w_sched) begin
                r_hold <= HW'(HOLD_CYC);
                r_pend <= w_drv;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
                if (r_hold == HW'(1)) r_sda_low <= r_pend;
            end
        end
    end

    assign sda       = (r_sda_low && !rst) ? 1'b0 : 1'bz;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = r_busy;
    assign ack       = r_ack;
endmodule
